// File: rtl/psa_pkg.sv
// psa_pkg: shared constants, FSM state type and saturation limits for the parallel sub-word subtractor.
package psa_pkg;
    localparam int LANE_W = 4;
    localparam int LANES  = 4;
    localparam int DATA_W = LANE_W * LANES;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
    localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;
endpackage

// File: rtl/psub_lane_4bit.sv
// psub_lane_4bit: combinational signed lane subtract y = a - b with overflow flag.
//   a, b : lane operands (signed two's complement)
//   y    : lane difference (saturated on overflow when PSUB_SAT_EN is defined, raw wrap otherwise)
//   ovfl : signed overflow of a - b
module psub_lane_4bit
    import psa_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] y,
    output logic              ovfl
);
    logic [LANE_W-1:0] d;
    assign d    = a + ~b + LANE_W'(1);
    // Overflow only possible when operand signs differ and the result sign leaves the minuend's sign.
    assign ovfl = (a[LANE_W-1] != b[LANE_W-1]) && (d[LANE_W-1] != a[LANE_W-1]);
`ifdef PSUB_SAT_EN
    assign y = ovfl ? (a[LANE_W-1] ? SAT_NEG : SAT_POS) : d;
`else
    assign y = d;
`endif
endmodule

// File: rtl/psub_16bit_seq.sv
// psub_16bit_seq: handshaked multi-cycle subtractor, four signed 4-bit lanes, one lane per clock, LSB lane first.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   A, B                 : packed minuend / subtrahend lanes
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   Diff, lane_ovfl      : packed lane differences, per-lane overflow flags
//   Error                : OR of lane_ovfl
//   Build option PSUB_SAT_EN: saturate overflowed lanes instead of wrapping.
module psub_16bit_seq
    import psa_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Diff,
    output logic [LANES-1:0]  lane_ovfl,
    output logic              Error
);
    state_t            state_q, state_d;
    logic [1:0]        lane_cnt_q, lane_cnt_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [LANES-1:0]  ovfl_q, ovfl_d;
    logic [LANE_W-1:0] lane_y;
    logic              lane_ov;

    // Single lane unit shared across lanes through the lane_cnt select.
    psub_lane_4bit u_lane (
        .a    (a_q[lane_cnt_q*LANE_W +: LANE_W]),
        .b    (b_q[lane_cnt_q*LANE_W +: LANE_W]),
        .y    (lane_y),
        .ovfl (lane_ov)
    );

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        diff_d     = diff_q;
        ovfl_d     = ovfl_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d        = A;
                b_d        = B;
                lane_cnt_d = '0;
                diff_d     = '0;
                ovfl_d     = '0;
                state_d    = RUN;
            end
            RUN: begin
                diff_d[lane_cnt_q*LANE_W +: LANE_W] = lane_y;
                ovfl_d[lane_cnt_q]                  = lane_ov;
                lane_cnt_d                          = lane_cnt_q + 2'd1;
                state_d = (lane_cnt_q == 2'(LANES-1)) ? DONE : RUN;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            diff_q     <= '0;
            ovfl_q     <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            diff_q     <= diff_d;
            ovfl_q     <= ovfl_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Diff      = diff_q;
    assign lane_ovfl = ovfl_q;
    assign Error     = |ovfl_q;
endmodule

// File: tb/tb_psub_16bit_seq.sv
// tb_psub_16bit_seq: randomized and directed bench for psub_16bit_seq against a lane-arithmetic model.
module tb_psub_16bit_seq;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, Error;
    logic [15:0] A = 0, B = 0, Diff;
    logic [3:0]  lane_ovfl;
    int          n_checks = 0, n_err = 0;

    psub_16bit_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Diff(Diff), .lane_ovfl(lane_ovfl), .Error(Error)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Signed integer subtraction per lane; result {ovfl[3:0], diff[15:0]}.
    function automatic logic [19:0] ref_op(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        logic [3:0]  o;
        for (int i = 0; i < 4; i++) begin
            int x, y, r;
            x = $signed(a[i*4 +: 4]);
            y = $signed(b[i*4 +: 4]);
            r = x - y;
            o[i] = (r > 7) || (r < -8);
`ifdef PSUB_SAT_EN
            if (r > 7) r = 7;
            else if (r < -8) r = -8;
`endif
            d[i*4 +: 4] = r[3:0];
        end
        return {o, d};
    endfunction

    // Transaction-level model: idle / busy for four edges / holding result.
    int          m_ph = 0, m_cnt = 0;
    bit          m_live = 0;
    logic [19:0] m_res = '0, m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph   <= 0;
            m_cnt  <= 0;
            m_res  <= '0;
            m_live <= 1;
        end else if (m_ph == 0) begin
            if (in_valid) begin
                m_pend <= ref_op(A, B);
                m_cnt  <= 4;
                m_ph   <= 1;
            end
        end else if (m_ph == 1) begin
            if (m_cnt == 1) begin
                m_ph  <= 2;
                m_res <= m_pend;
            end else m_cnt <= m_cnt - 1;
        end else if (out_ready) m_ph <= 0;
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready", in_ready, m_ph == 0);
            check("out_valid", out_valid, m_ph == 2);
            if (m_ph != 1) begin
                check("Diff", Diff, m_res[15:0]);
                check("lane_ovfl", lane_ovfl, m_res[19:16]);
            end
            if (m_ph == 2) check("Error", Error, |m_res[19:16]);
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit scramble, output int lat);
        A = a;
        B = b;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (scramble) begin
                A = 16'($urandom);
                B = 16'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    int lat;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", Diff, 16'h0000);
        check("rst_ovfl", lane_ovfl, 4'b0000);

        run_op(16'h1234, 16'h1111, 0, lat);
        check("t1_latency", lat, 4);
        check("t1_diff", Diff, 16'h0123);
        check("t1_ovfl", lane_ovfl, 4'b0000);
        check("t1_error", Error, 0);
        take();

        run_op(16'h8000, 16'h1000, 0, lat);
        check("t2_ovfl", lane_ovfl, 4'b1000);
        check("t2_error", Error, 1);
`ifdef PSUB_SAT_EN
        check("t2_diff", Diff, 16'h8000);
`else
        check("t2_diff", Diff, 16'h7000);
`endif
        take();

        run_op(16'h0007, 16'h000F, 0, lat);
        check("t3_ovfl", lane_ovfl, 4'b0001);
`ifdef PSUB_SAT_EN
        check("t3_diff", Diff, 16'h0007);
`else
        check("t3_diff", Diff, 16'h0008);
`endif
        take();

        run_op(16'h2345, 16'h1111, 0, lat);
        in_valid = 1;
        A = 16'h7777;
        B = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_diff", Diff, 16'h1234);
            check("t4_hold_in_ready", in_ready, 0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check("t4_back_idle", in_ready, 1);
        check("t4_no_overlap", out_valid, 0);
        run_op(16'h4444, 16'h1111, 0, lat);
        check("t4_second_latency", lat, 4);
        check("t4_second_diff", Diff, 16'h3333);
        take();

        A = 16'h3333;
        B = 16'h1111;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("t5_in_ready", in_ready, 1);
        check("t5_out_valid", out_valid, 0);
        check("t5_diff", Diff, 16'h0000);
        run_op(16'hFFFF, 16'hFFFF, 0, lat);
        check("t5_new_diff", Diff, 16'h0000);
        check("t5_new_error", Error, 0);
        take();

        run_op(16'h5A5A, 16'h1111, 1, lat);
        check("t6_diff", Diff, 16'h4949);
        check("t6_error", Error, 0);
        take();

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(63) == 0);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(2) != 0);
            A         = 16'($urandom);
            B         = 16'($urandom);
            @(posedge clk); #1;
        end
        rst = 0;
        in_valid = 0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
